// File: rtl/ahb_input_stage.sv
// ahb_input_stage
//   Slave-facing input port of an AHB matrix. The master's address phase is
//   forwarded toward an output stage live when that stage can take it at
//   once. It is parked in holding registers (PEND) when the output stage is
//   busy with another port. The data-phase ready/response is returned to the
//   master.
// Ports:
//   HCLK, HRESETn            clock, async active-low reset
//   HSELS..HMASTLOCKS        master-side address/control
//   HREADYS                  master-side HREADY (address phase sampled)
//   HREADYOUTS, HRESPS       ready/response returned to master
//   sel_ip..mastlock_ip      forwarded address/control to the output stage
//   held_tran_ip             a valid transfer is presented to the output stage
//   active_ip, readyin_ip    output stage selected this port / its HREADYMUXM
//   readyout_ip, resp_ip     slave data-phase ready/response
module ahb_input_stage (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic [3:0]  HMASTERS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  output logic        HREADYOUTS,
  output logic        HRESPS,
  output logic        sel_ip,
  output logic [31:0] addr_ip,
  output logic [1:0]  trans_ip,
  output logic        write_ip,
  output logic [2:0]  size_ip,
  output logic [2:0]  burst_ip,
  output logic [3:0]  prot_ip,
  output logic [3:0]  master_ip,
  output logic        mastlock_ip,
  output logic        held_tran_ip,
  input  logic        active_ip,
  input  logic        readyin_ip,
  input  logic        readyout_ip,
  input  logic        resp_ip
);

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        mastlock;
  } ahb_ctrl_t;

  typedef enum logic [1:0] {IDLE, PEND, DATA} state_t;

  state_t    state;
  ahb_ctrl_t live, hold, fwd;
  logic      new_tran, accept;

  assign live = '{sel: HSELS, addr: HADDRS, trans: HTRANSS, write: HWRITES,
                  size: HSIZES, burst: HBURSTS, prot: HPROTS,
                  master: HMASTERS, mastlock: HMASTLOCKS};

  // IDLE/BUSY never count as a transfer; they pass through live.
  assign new_tran = HSELS & HTRANSS[1] & HREADYS;
  assign accept   = active_ip & readyin_ip;

  // Holding registers track every completed address phase so that the
  // contents are already correct in the cycle the FSM moves to PEND.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     hold <= '0;
    else if (HREADYS) hold <= live;
  end

  // A single state register: an accept in PEND always leaves PEND, so a
  // held transfer is taken exactly once. Completion of DATA and a new
  // accepted transfer on the same edge go straight DATA->DATA.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else begin
      case (state)
        IDLE: if (new_tran) state <= accept ? DATA : PEND;
        PEND: if (accept)   state <= DATA;
        DATA: if (readyout_ip) begin
                if (new_tran) state <= accept ? DATA : PEND;
                else          state <= IDLE;
              end
        default: state <= IDLE;
      endcase
    end
  end

  // Live path outside PEND keeps zero added latency when the port is active.
  assign fwd = (state == PEND) ? hold : live;

  assign sel_ip      = fwd.sel;
  assign addr_ip     = fwd.addr;
  assign trans_ip    = fwd.trans;
  assign write_ip    = fwd.write;
  assign size_ip     = fwd.size;
  assign burst_ip    = fwd.burst;
  assign prot_ip     = fwd.prot;
  assign master_ip   = fwd.master;
  assign mastlock_ip = fwd.mastlock;

  assign held_tran_ip = (state == PEND) | new_tran;

  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;
    case (state)
      PEND: HREADYOUTS = 1'b0;
      DATA: begin
        HREADYOUTS = readyout_ip;
        HRESPS     = resp_ip;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_input_stage.sv
module tb_ahb_input_stage;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        HSELS, HWRITES, HMASTLOCKS, HREADYS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS, HMASTERS;
  logic        HREADYOUTS, HRESPS;
  logic        sel_ip, write_ip, mastlock_ip, held_tran_ip;
  logic [31:0] addr_ip;
  logic [1:0]  trans_ip;
  logic [2:0]  size_ip, burst_ip;
  logic [3:0]  prot_ip, master_ip;
  logic        active_ip, readyin_ip, readyout_ip, resp_ip;

  always #5 HCLK = ~HCLK;

  ahb_input_stage dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS),
    .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .sel_ip(sel_ip), .addr_ip(addr_ip), .trans_ip(trans_ip),
    .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip),
    .prot_ip(prot_ip), .master_ip(master_ip), .mastlock_ip(mastlock_ip),
    .held_tran_ip(held_tran_ip), .active_ip(active_ip),
    .readyin_ip(readyin_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip)
  );

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        readys, mlock, active, readyin, readyout, resp;
    logic        e_rdy, e_resp, e_held;
    logic [31:0] e_addr;
    logic        e_mlock;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0, failures = 0;

  function automatic vec_t mk(logic sel, logic [31:0] addr, logic [1:0] trans,
                              logic readys, logic mlock, logic active,
                              logic readyin, logic readyout, logic resp,
                              logic e_rdy, logic e_resp, logic e_held,
                              logic [31:0] e_addr, logic e_mlock);
    vec_t v;
    v.sel = sel; v.addr = addr; v.trans = trans; v.readys = readys;
    v.mlock = mlock; v.active = active; v.readyin = readyin;
    v.readyout = readyout; v.resp = resp; v.e_rdy = e_rdy;
    v.e_resp = e_resp; v.e_held = e_held; v.e_addr = e_addr;
    v.e_mlock = e_mlock;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    HSELS = v.sel; HADDRS = v.addr; HTRANSS = v.trans; HREADYS = v.readys;
    HMASTLOCKS = v.mlock; active_ip = v.active; readyin_ip = v.readyin;
    readyout_ip = v.readyout; resp_ip = v.resp;
  endtask

  task automatic compare_head(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty got=0 exp=1", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".hreadyouts"}, 32'(HREADYOUTS), 32'(e.e_rdy));
    chk({tag, ".hresps"},     32'(HRESPS),     32'(e.e_resp));
    chk({tag, ".held"},       32'(held_tran_ip), 32'(e.e_held));
    chk({tag, ".addr"},       addr_ip,         e.e_addr);
    chk({tag, ".mastlock"},   32'(mastlock_ip), 32'(e.e_mlock));
  endtask

  // Drive one cycle's inputs after the active edge, compare on the falling edge.
  task automatic step(input vec_t v, input string tag);
    drive(v);
    exp_q.push_back(v);
    @(negedge HCLK);
    compare_head(tag);
    @(posedge HCLK); #1;
  endtask

  vec_t idle_v;

  initial begin
    HWRITES = 1'b1; HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3;
    HMASTERS = 4'h1;
    idle_v = mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    drive(idle_v);

    // Active port, wait state, return to IDLE
    vecs.push_back(mk(1, 32'h2000_0010, 2, 1, 0, 1, 1, 1, 0, 1, 0, 1, 32'h2000_0010, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    // Inactive port: 3 cycles PEND, holding regs stable, locked
    vecs.push_back(mk(1, 32'h3000_0040, 2, 1, 1, 0, 1, 1, 0, 1, 0, 1, 32'h3000_0040, 1));
    vecs.push_back(mk(1, 32'hDEAD_BEEF, 2, 0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h3000_0040, 1));
    vecs.push_back(mk(1, 32'hDEAD_BEEF, 2, 0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h3000_0040, 1));
    vecs.push_back(mk(1, 32'hDEAD_BEEF, 2, 0, 0, 1, 1, 1, 0, 0, 0, 1, 32'h3000_0040, 1));
    vecs.push_back(mk(0, 32'hDEAD_BEEF, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 32'hDEAD_BEEF, 0));
    // Wait states, back-to-back, then two-cycle ERROR
    vecs.push_back(mk(1, 32'h40, 2, 1, 0, 1, 1, 1, 0, 1, 0, 1, 32'h40, 0));
    vecs.push_back(mk(1, 32'h44, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h44, 0));
    vecs.push_back(mk(1, 32'h44, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h44, 0));
    vecs.push_back(mk(1, 32'h44, 2, 1, 0, 1, 1, 1, 0, 1, 0, 1, 32'h44, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    // BUSY with HSELS=1 stays IDLE
    vecs.push_back(mk(1, 32'h55, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 32'h55, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    // DATA -> PEND -> DATA -> IDLE
    vecs.push_back(mk(1, 32'h50, 2, 1, 0, 1, 1, 1, 0, 1, 0, 1, 32'h50, 0));
    vecs.push_back(mk(1, 32'h60, 2, 1, 0, 0, 1, 1, 0, 1, 0, 1, 32'h60, 0));
    vecs.push_back(mk(1, 32'h99, 2, 0, 0, 0, 1, 1, 0, 0, 0, 1, 32'h60, 0));
    vecs.push_back(mk(1, 32'h99, 2, 0, 0, 1, 1, 1, 0, 0, 0, 1, 32'h60, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    // Selected but output stage not ready -> PEND
    vecs.push_back(mk(1, 32'h70, 2, 1, 0, 1, 0, 1, 0, 1, 0, 1, 32'h70, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 32'h70, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0));

    // Reset state
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("reset.hreadyouts", 32'(HREADYOUTS), 32'd1);
    chk("reset.hresps", 32'(HRESPS), 32'd0);
    chk("reset.held", 32'(held_tran_ip), 32'd0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i], $sformatf("vec%0d", i));

    // INCR4 back-to-back; reset lands during the 3rd beat
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      a = 32'h100 + 32'(4 * k);
      step(mk(1, a, (k == 0) ? 2'd2 : 2'd3, 1, 0, 1, 1, 1, 0, 1, 0, 1, a, 0),
           $sformatf("incr4_b%0d", k));
    end
    drive(mk(1, 32'h10C, 3, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    @(negedge HCLK);
    chk("incr4_b3.hreadyouts", 32'(HREADYOUTS), 32'd1);
    chk("incr4_b3.held", 32'(held_tran_ip), 32'd1);
    chk("incr4_b3.addr", addr_ip, 32'h10C);
    #2 HRESETn = 1'b0;
    drive(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rst_mid.hreadyouts", 32'(HREADYOUTS), 32'd1);
    chk("rst_mid.hresps", 32'(HRESPS), 32'd0);
    chk("rst_mid.held", 32'(held_tran_ip), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    step(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0), "post_rst_idle");
    step(mk(1, 32'h200, 2, 1, 0, 0, 1, 0, 0, 1, 0, 1, 32'h200, 0), "post_rst_new");
    step(mk(0, 32'h300, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h200, 0), "post_rst_pend");

    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
